// File: rtl/bju_resolve_pipe_if.sv
// bju_resolve_pipe_if: issue, result and predictor-update bundle for the branch resolution unit
// Ports (slave side = bju_resolve_pipe):
//   in : flush, in_valid, src1, src2, imm, pc, cx_type, is_unsigned, predict_taken, predict_target, upd_ready
//   out: in_ready, out_valid, dest, redirect_valid, redirect_target,
//        upd_valid, upd_index, upd_slot, upd_inc, upd_dec, upd_btb_we, upd_btb_wmask, upd_btb_din
interface bju_resolve_pipe_if #(
   parameter int XLEN            = 64,
   parameter int PC_WIDTH        = 48,
   parameter int TGT_WIDTH       = 32,
   parameter int SLOTS           = 4,
   parameter int BHT_INDEX_WIDTH = 9
);
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int BW     = 1 + SLOTS * TGT_WIDTH;
   logic                       flush;
   logic                       in_valid;
   logic                       in_ready;
   logic [XLEN-1:0]            src1;
   logic [XLEN-1:0]            src2;
   logic [XLEN-1:0]            imm;
   logic [PC_WIDTH-1:0]        pc;
   logic [5:0]                 cx_type;
   logic                       is_unsigned;
   logic                       predict_taken;
   logic [TGT_WIDTH-1:0]       predict_target;
   logic                       out_valid;
   logic [XLEN-1:0]            dest;
   logic                       redirect_valid;
   logic [PC_WIDTH-1:0]        redirect_target;
   logic                       upd_valid;
   logic                       upd_ready;
   logic [BHT_INDEX_WIDTH-1:0] upd_index;
   logic [SLOT_W-1:0]          upd_slot;
   logic                       upd_inc;
   logic                       upd_dec;
   logic                       upd_btb_we;
   logic [BW-1:0]              upd_btb_wmask;
   logic [BW-1:0]              upd_btb_din;
   modport master (
      output flush, in_valid, src1, src2, imm, pc, cx_type, is_unsigned, predict_taken, predict_target, upd_ready,
      input  in_ready, out_valid, dest, redirect_valid, redirect_target,
             upd_valid, upd_index, upd_slot, upd_inc, upd_dec, upd_btb_we, upd_btb_wmask, upd_btb_din
   );
   modport slave (
      input  flush, in_valid, src1, src2, imm, pc, cx_type, is_unsigned, predict_taken, predict_target, upd_ready,
      output in_ready, out_valid, dest, redirect_valid, redirect_target,
             upd_valid, upd_index, upd_slot, upd_inc, upd_dec, upd_btb_we, upd_btb_wmask, upd_btb_din
   );
endinterface

// File: rtl/bju_resolve_pipe.sv
// bju_resolve_pipe: registered branch/jump resolution with a queued predictor-training stream
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   io     bju_resolve_pipe_if.slave: issue operands/prediction in, registered redirect/link out,
//          BHT/BTB update FIFO head out over upd_valid/upd_ready
module bju_resolve_pipe #(
   parameter int XLEN            = 64,
   parameter int PC_WIDTH        = 48,
   parameter int TGT_WIDTH       = 32,
   parameter int SLOTS           = 4,
   parameter int BHT_INDEX_WIDTH = 9,
   parameter int UPD_DEPTH       = 4
) (
   input logic             clk_i,
   input logic             rst_i,
   bju_resolve_pipe_if.slave io
);
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int PW     = $clog2(UPD_DEPTH);
   localparam int CW     = $clog2(UPD_DEPTH + 1);
   localparam int BW     = 1 + SLOTS * TGT_WIDTH;
   localparam int EW     = BHT_INDEX_WIDTH + SLOT_W + 2 + TGT_WIDTH;
   logic                 eq, lt, taken, tgt_ok, mispred, rdy, accept, upd_vld, pop;
   logic [PC_WIDTH-1:0]  tgt, pc4;
   logic [EW-1:0]        entry_d;
   logic                 out_valid_q, out_valid_d, redir_valid_q, redir_valid_d;
   logic [XLEN-1:0]      dest_q, dest_d;
   logic [PC_WIDTH-1:0]  redir_tgt_q, redir_tgt_d;
   logic [EW-1:0]        mem_q [UPD_DEPTH];
   logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic [BHT_INDEX_WIDTH-1:0] h_idx;
   logic [SLOT_W-1:0]    h_slot;
   logic                 h_inc, h_we;
   logic [TGT_WIDTH-1:0] h_tgt;
   always_comb begin
      eq      = io.src1 == io.src2;
      lt      = io.is_unsigned ? (io.src1 < io.src2) : ($signed(io.src1) < $signed(io.src2));
      taken   = io.cx_type[0] | io.cx_type[1] | (io.cx_type[2] & eq) | (io.cx_type[3] & ~eq)
                | (io.cx_type[4] & lt) | (io.cx_type[5] & ~lt);
      // JALR drops bit 0 of the register-relative sum; everything else is pc-relative
      tgt     = io.cx_type[1] ? (PC_WIDTH'(io.src1 + io.imm) & ~PC_WIDTH'(1)) : io.pc + PC_WIDTH'(io.imm);
      pc4     = io.pc + PC_WIDTH'(4);
      tgt_ok  = tgt[TGT_WIDTH-1:0] == io.predict_target;
      mispred = taken ? (~io.predict_taken | ~tgt_ok) : io.predict_taken;
      rdy     = count_q < CW'(UPD_DEPTH);
      accept  = io.in_valid & rdy & ~io.flush;
      upd_vld = count_q != '0;
      pop     = upd_vld & io.upd_ready;
      // a taken mispredict is the only case that needs the BTB rewritten
      entry_d = {io.pc[BHT_INDEX_WIDTH+SLOT_W+1:SLOT_W+2], io.pc[SLOT_W+1:2], taken, taken & mispred, tgt[TGT_WIDTH-1:0]};
      out_valid_d   = accept;
      dest_d        = accept ? XLEN'(pc4) : '0;
      redir_valid_d = accept & mispred;
      redir_tgt_d   = (accept & mispred) ? (taken ? tgt : pc4) : '0;
      head_d  = pop ? head_q + PW'(1) : head_q;
      tail_d  = accept ? tail_q + PW'(1) : tail_q;
      count_d = count_q + CW'(accept) - CW'(pop);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q   <= 1'b0;
         redir_valid_q <= 1'b0;
         dest_q        <= '0;
         redir_tgt_q   <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         redir_valid_q <= redir_valid_d;
         dest_q        <= dest_d;
         redir_tgt_q   <= redir_tgt_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
      end
   end
   // storage needs no reset: every read is qualified by count
   always_ff @(posedge clk_i)
      if (accept) mem_q[tail_q] <= entry_d;
   assign {h_idx, h_slot, h_inc, h_we, h_tgt} = mem_q[head_q];
   assign io.in_ready        = rdy;
   assign io.out_valid       = out_valid_q;
   assign io.dest            = dest_q;
   assign io.redirect_valid  = redir_valid_q;
   assign io.redirect_target = redir_tgt_q;
   assign io.upd_valid       = upd_vld;
   assign io.upd_index       = upd_vld ? h_idx : '0;
   assign io.upd_slot        = upd_vld ? h_slot : '0;
   assign io.upd_inc         = upd_vld & h_inc;
   assign io.upd_dec         = upd_vld & ~h_inc;
   assign io.upd_btb_we      = upd_vld & h_we;
   assign io.upd_btb_wmask   = upd_vld ? ({1'b1, {(BW-1){1'b0}}}
                               | ({{(BW-TGT_WIDTH){1'b0}}, {TGT_WIDTH{1'b1}}} << (int'(h_slot) * TGT_WIDTH))) : '0;
   assign io.upd_btb_din     = upd_vld ? ({1'b1, {(BW-1){1'b0}}}
                               | ({{(BW-TGT_WIDTH){1'b0}}, h_tgt} << (int'(h_slot) * TGT_WIDTH))) : '0;
endmodule

// File: tb/tb_bju_resolve_pipe.sv
// tb_bju_resolve_pipe: vector table plus scoreboard queues for results and predictor updates
module tb_bju_resolve_pipe;
   typedef struct {
      logic [5:0] t; logic u; logic [63:0] s1; logic [63:0] s2; logic [63:0] imm; logic [47:0] pc;
      logic pt; logic [31:0] ptgt;
      logic rv; logic [47:0] rt; logic [63:0] dest; logic [8:0] idx; logic [1:0] slot; logic inc; logic we; logic [31:0] tgt;
   } vec_t;
   typedef struct { logic rv; logic [47:0] rt; logic [63:0] dest; } out_t;
   typedef struct { logic [8:0] idx; logic [1:0] slot; logic inc; logic we; logic [31:0] tgt; } upd_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   vec_t tbl [12];
   out_t out_q [$];
   upd_t upd_q [$];
   out_t o;
   upd_t u;
   logic [128:0] em, ed;
   bju_resolve_pipe_if bus ();
   bju_resolve_pipe dut (.clk_i(clk), .rst_i(rst), .io(bus));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [159:0] a, input logic [159:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input vec_t v);
      bus.cx_type = v.t; bus.is_unsigned = v.u; bus.src1 = v.s1; bus.src2 = v.s2; bus.imm = v.imm;
      bus.pc = v.pc; bus.predict_taken = v.pt; bus.predict_target = v.ptgt; bus.in_valid = 1'b1;
   endtask
   task automatic push_exp(input vec_t v);
      out_q.push_back('{v.rv, v.rt, v.dest});
      upd_q.push_back('{v.idx, v.slot, v.inc, v.we, v.tgt});
   endtask
   always @(negedge clk) if (!rst) begin
      if (bus.out_valid) begin
         if (out_q.size() == 0) chk("unexpected_out_valid", 1, 0);
         else begin
            o = out_q.pop_front();
            chk("redirect_valid", bus.redirect_valid, o.rv);
            chk("redirect_target", bus.redirect_target, o.rt);
            chk("dest", bus.dest, o.dest);
         end
      end else begin
         chk("idle_dest", bus.dest, 0);
         chk("idle_redirect", bus.redirect_valid, 0);
      end
      if (bus.upd_valid && bus.upd_ready) begin
         if (upd_q.size() == 0) chk("unexpected_upd_pop", 1, 0);
         else begin
            u = upd_q.pop_front();
            chk("upd_index", bus.upd_index, u.idx);
            chk("upd_slot", bus.upd_slot, u.slot);
            chk("upd_inc", bus.upd_inc, u.inc);
            chk("upd_dec", bus.upd_dec, !u.inc);
            chk("upd_btb_we", bus.upd_btb_we, u.we);
            em = '0; em[128] = 1'b1; em[u.slot*32 +: 32] = '1;
            chk("upd_btb_wmask", bus.upd_btb_wmask, em);
            if (u.we) begin
               ed = '0; ed[128] = 1'b1; ed[u.slot*32 +: 32] = u.tgt;
               chk("upd_btb_din", bus.upd_btb_din, ed);
            end
         end
      end
   end
   initial begin
      //           type   u  src1                    src2                    imm                     pc                 pt ptgt
      //           rv rt               dest                     idx     slot inc we tgt
      tbl[0]  = '{6'h04, 0, 64'd5,                  64'd5,                  64'h20,                 48'h1008,          0, 32'h0,
                  1, 48'h1028,        64'h100C,                9'h100, 2'd2, 1, 1, 32'h1028};
      tbl[1]  = '{6'h10, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 64'h40,                 48'h2000,          1, 32'h2040,
                  0, 48'h0,           64'h2004,                9'h000, 2'd0, 1, 0, 32'h2040};
      tbl[2]  = '{6'h10, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 64'h40,                 48'h2000,          1, 32'h2040,
                  1, 48'h2004,        64'h2004,                9'h000, 2'd0, 0, 0, 32'h0};
      tbl[3]  = '{6'h02, 0, 64'h2001,               64'd0,                  64'h0,                  48'h3000,          1, 32'h2000,
                  0, 48'h0,           64'h3004,                9'h100, 2'd0, 1, 0, 32'h2000};
      tbl[4]  = '{6'h01, 0, 64'd0,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFF8, 48'h1004,         1, 32'h0FF0,
                  1, 48'hFFC,         64'h1008,                9'h100, 2'd1, 1, 1, 32'hFFC};
      tbl[5]  = '{6'h08, 0, 64'd3,                  64'd3,                  64'h100,                48'h10,            0, 32'h0,
                  0, 48'h0,           64'h14,                  9'h001, 2'd0, 0, 0, 32'h0};
      tbl[6]  = '{6'h20, 0, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 64'h10,               48'h44,            0, 32'h0,
                  1, 48'h54,          64'h48,                  9'h004, 2'd1, 1, 1, 32'h54};
      tbl[7]  = '{6'h20, 1, 64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 64'h8,                 48'h80,            0, 32'h0,
                  0, 48'h0,           64'h84,                  9'h008, 2'd0, 0, 0, 32'h0};
      tbl[8]  = '{6'h10, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h20,               48'h100,           1, 32'h120,
                  1, 48'h104,         64'h104,                 9'h010, 2'd0, 0, 0, 32'h0};
      tbl[9]  = '{6'h01, 0, 64'd0,                  64'd0,                  64'h20,                 48'hFFFF_FFFF_FFF0, 1, 32'h10,
                  0, 48'h0,           64'hFFFF_FFFF_FFF4,      9'h1FF, 2'd0, 1, 0, 32'h10};
      tbl[10] = '{6'h02, 0, 64'h5000,               64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 48'h8,            0, 32'h0,
                  1, 48'h4FFE,        64'hC,                   9'h000, 2'd2, 1, 1, 32'h4FFE};
      tbl[11] = '{6'h01, 0, 64'd0,                  64'd0,                  64'h10,                 48'h1_0000_0000,   1, 32'h10,
                  0, 48'h0,           64'h1_0000_0004,         9'h000, 2'd0, 1, 0, 32'h10};
      bus.flush = 0; bus.in_valid = 0; bus.upd_ready = 0; bus.src1 = 0; bus.src2 = 0; bus.imm = 0;
      bus.pc = 0; bus.cx_type = 0; bus.is_unsigned = 0; bus.predict_taken = 0; bus.predict_target = 0;
      #1 rst = 1;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_upd_valid", bus.upd_valid, 0);
      chk("rst_redirect", bus.redirect_valid, 0);
      chk("rst_wmask", bus.upd_btb_wmask, 0);
      tick(); tick();
      rst = 0;
      bus.upd_ready = 1;
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i]); push_exp(tbl[i]); tick();
      end
      bus.in_valid = 0;
      tick(); tick();
      bus.upd_ready = 0;
      for (int i = 0; i < 4; i++) begin
         drive(tbl[i]); push_exp(tbl[i]); tick();
      end
      chk("full_in_ready", bus.in_ready, 0);
      drive(tbl[4]); tick();
      bus.in_valid = 0;
      chk("full_ignored_out", bus.out_valid, 0);
      chk("full_still_blocked", bus.in_ready, 0);
      bus.upd_ready = 1; tick();
      chk("ready_after_pop", bus.in_ready, 1);
      repeat (4) tick();
      chk("drain_a_empty", bus.upd_valid, 0);
      bus.upd_ready = 0;
      for (int i = 5; i < 8; i++) begin
         drive(tbl[i]); push_exp(tbl[i]); tick();
      end
      bus.upd_ready = 1; drive(tbl[8]); push_exp(tbl[8]); tick();
      chk("pushpop_in_ready", bus.in_ready, 1);
      bus.upd_ready = 0; drive(tbl[9]); push_exp(tbl[9]); tick();
      chk("wrap_full", bus.in_ready, 0);
      bus.in_valid = 0; bus.upd_ready = 1;
      repeat (5) tick();
      chk("drain_b_empty", bus.upd_valid, 0);
      bus.upd_ready = 0;
      drive(tbl[10]); push_exp(tbl[10]); tick();
      drive(tbl[11]); bus.flush = 1; tick();
      bus.flush = 0; bus.in_valid = 0;
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_redirect", bus.redirect_valid, 0);
      chk("flush_kept_entry", bus.upd_valid, 1);
      bus.upd_ready = 1;
      repeat (3) tick();
      chk("drain_c_empty", bus.upd_valid, 0);
      bus.upd_ready = 0;
      for (int i = 0; i < 3; i++) begin
         drive(tbl[i]); push_exp(tbl[i]); tick();
      end
      bus.in_valid = 0; bus.upd_ready = 1; tick();
      #2 rst = 1;
      upd_q.delete();
      #1;
      chk("midrst_upd_valid", bus.upd_valid, 0);
      chk("midrst_upd_inc", bus.upd_inc | bus.upd_dec, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      tick(); tick();
      rst = 0;
      drive(tbl[4]); push_exp(tbl[4]); tick();
      bus.in_valid = 0;
      tick(); tick();
      chk("out_q_empty", out_q.size(), 0);
      chk("upd_q_empty", upd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
